div_iter: RTL and testbench

Multicycle signed 32-bit integer divider inside the multdiv unit, directly downstream of the ALU's 32-bit ripple subtractor: each iteration consumes one trial subtraction (remainder minus divisor) and keeps or discards the difference. It accepts a start pulse, runs 32 restoring-division iterations, applies sign correction, and reports the quotient with a one-cycle ready strobe. Divide-by-zero and the single signed-overflow case are flagged as exceptions.

---
 rtl/div_iter.sv | 100 ++++++++++
 tb/tb_div_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Multicycle signed 32-bit restoring divider: one trial subtraction per cycle,
// sign correction in FIX, exceptions for divide-by-zero and MIN / -1.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    counter_reg;
  logic [WIDTH-1:0] q_reg;
  // The remainder never exceeds |B| after a kept step, so its 33rd bit is always 0.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] div_mag_reg;
  logic             sign_reg;

  logic             accept, iterate, div_zero, overflow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, trial;

  assign div_zero = (data_operandB == '0);
  assign overflow = (data_operandA == MIN_VAL) && (data_operandB == '1);
  assign a_mag    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign b_mag    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  // Trial subtraction as invert-plus-one, matching the upstream ripple subtractor.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign trial   = r_shift + {1'b1, ~div_mag_reg} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (ctrl_DIV) state_next = (div_zero || overflow) ? DONE : RUN;
        else          state_next = IDLE;
      end
      RUN:     if (counter_reg == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept  = ctrl_DIV && ((state_reg == IDLE) || (state_reg == DONE));
    iterate = (state_reg == RUN);
    busy    = (state_reg == RUN) || (state_reg == FIX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_reg    <= '0;
      q_reg          <= '0;
      r_reg          <= '0;
      div_mag_reg    <= '0;
      sign_reg       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (accept) begin
      counter_reg    <= '0;
      q_reg          <= a_mag;
      r_reg          <= '0;
      div_mag_reg    <= b_mag;
      sign_reg       <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_result    <= (!div_zero && overflow) ? MIN_VAL : '0;
      data_exception <= div_zero || overflow;
      data_resultRDY <= div_zero || overflow;
    end else if (iterate) begin
      counter_reg    <= counter_reg + 1'b1;
      r_reg          <= trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_reg          <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
      data_resultRDY <= 1'b0;
    end else if (state_reg == FIX) begin
      data_result    <= sign_reg ? (~q_reg + 1'b1) : q_reg;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expectations, a negedge
// monitor pops them whenever data_resultRDY pulses.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div_iter #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          c0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain signed division (truncates toward zero) plus the two exception cases.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa, sbv;
    sa  = a;
    sbv = b;
    e.c0 = 0;
    if (b == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.lat = 0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1'b1; e.lat = 0;
    end else begin
      e.res = sa / sbv; e.exc = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset && data_resultRDY) begin
      check("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy actual=1 required=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("latency", cyc - e.c0, e.lat);
        $display("op done: result=0x%08h exc=%0d latency=%0d", data_result, data_exception, cyc - e.c0);
      end
      done_cnt++;
    end
    prev_rdy = reset && data_resultRDY;
  end

  // Drives a start request; returns one time step after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    e    = model(a, b);
    e.c0 = cyc;
    sb.push_back(e);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int base, n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout actual=none required=pulse t=%0t", $time);
    end
  endtask

  initial begin
    logic [31:0] a, b;

    #12;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    start(32'd100, 32'd7);
    check("busy_running", {31'd0, busy}, 32'd1);
    check("result_zero_running", data_result, 32'd0);
    wait_done();
    check("busy_after_done", {31'd0, busy}, 32'd0);

    start(-32'sd100, 32'd7);    wait_done();
    start(32'd100, -32'sd7);    wait_done();
    start(-32'sd100, -32'sd7);  wait_done();
    start(32'd5, 32'd0);        wait_done();
    start(32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    start(32'h8000_0000, 32'd1);         wait_done();

    // Requests and operand changes during RUN/FIX are ignored; restart in the RDY cycle.
    start(32'd1000, 32'd3);
    repeat (32) begin
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'($urandom);
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
    @(posedge clock);
    #1;
    check("rdy_at_e33", {31'd0, data_resultRDY}, 32'd1);
    start(32'd9, 32'd2);
    wait_done();

    // Reset mid-RUN aborts with no RDY.
    start(32'd1000, 32'd3);
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_result", data_result, 32'd0);
    check("abort_exception", {31'd0, data_exception}, 32'd0);
    check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    start(32'h7FFF_FFFF, 32'd1);
    wait_done();

    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      if ($urandom_range(0, 1) == 0) b = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 0) a = -a;
      if ($urandom_range(0, 1) == 0) b = -b;
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      start(a, b);
      wait_done();
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
